btb_predictor: RTL and testbench
================================

# btb_predictor

Two-bit dynamic branch predictor with a direct-mapped branch target buffer. It sits beside the IF stage of the five-stage MIPS pipeline. Each cycle it turns the fetch PC into a predicted next PC. It also takes branch resolutions from stage 4 (MEM) and trains its saturating counters and targets. When a resolved outcome contradicts the prediction carried down the pipe, it raises a redirect so the pipeline can flush.

## Interface
Parameters:
- ENTRIES, 16: table depth; power of two, 4..256. IDX_W = log2(ENTRIES).
- INIT_CTR, 2'b01: counter value loaded by reset and by invalidate.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- lookup_en  in  1  fetch active; low during stall_s1_s2
- pc  in  32  fetch PC (stage 1)
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predict taken
- pred_next_pc  out  32  predicted next fetch PC
- upd_valid  in  1  a beq/bne resolves in stage 4 this cycle
- upd_pc  in  32  PC of the resolving branch
- upd_taken  in  1  actual outcome (pcsrc)
- upd_target  in  32  actual branch target (baddr_s4)
- upd_pred_taken  in  1  prediction made at fetch, carried with the branch
- upd_pred_target  in  32  predicted target carried with the branch
- inv  in  1  synchronous invalidate-all
- redirect_valid  out  1  misprediction detected
- redirect_pc  out  32  correct next PC on misprediction
- stat_branches  out  16  resolved-branch count
- stat_mispredicts  out  16  misprediction count

## Operation
- Entry contents: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2].
- Lookup (combinational):
  - pred_hit = lookup_en & valid[idx] & (tag == pc tag).
  - pred_taken = pred_hit & ctr[1].
  - pred_next_pc = pred_taken ? target : pc+4 (32-bit wrap).
- Update, on upd_valid at the clock edge, indexed by upd_pc:
  - Hit and taken: ctr saturating increment (max 2'b11); target <= upd_target.
  - Hit and not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss and taken: allocate. valid=1, tag and target written, ctr=2'b10. Any aliasing entry is overwritten.
  - Miss and not taken: no change.
- Misprediction (combinational):
  - redirect_valid = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect_pc is 0 when redirect_valid is low.
- inv: at the edge, all valid bits clear and all ctr bits are set to INIT_CTR. inv overrides a same-cycle update, so nothing is allocated or trained.
- Reset:
  - All valid = 0, ctr = INIT_CTR, stats = 0.
  - Targets and tags are don't-care.
  - Outputs during reset: pred_hit 0, pred_taken 0, pred_next_pc = pc+4, redirect per its equations.

## Timing
- Lookup latency: 0 cycles. The outputs depend on pc and the current table state.
- Update latency: 1 cycle. It is visible to a lookup in the cycle after the edge.
- Same-index lookup and update in one cycle: the lookup returns the old entry (read-before-write).
- Redirect is combinational in the upd_valid cycle. The CPU uses it as the flush/PC-select source at the same edge.
- lookup_en low: no state change from the lookup side; updates still proceed.
- rst_n asserted mid-operation: state clears immediately and asynchronously. Updates in flight are lost.

## Configuration
- BTB_STATS_EN defined:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments on every redirect_valid.
  - Both saturate at 16'hFFFF and are not cleared by inv.
- BTB_STATS_EN undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset, then lookup pc=0x40 -> pred_hit 0, pred_taken 0, pred_next_pc 0x44.
- Allocate: upd pc=0x40, taken=1, target=0x100, pred_taken=0 -> redirect_valid 1, redirect_pc 0x100. Next cycle, lookup 0x40 -> hit 1, taken 1, next 0x100.
- Hysteresis:
  - Two more taken updates at 0x40 -> ctr 11.
  - One not-taken update -> still predicts 0x100.
  - A second not-taken update -> ctr 01, predicts 0x44. A not-taken update with upd_pred_taken=1 gives redirect_pc 0x44.
- Aliasing (ENTRIES=16):
  - Taken update at 0x80, target 0x200 -> replaces the 0x40 entry.
  - Lookup 0x40 -> miss. Lookup 0x80 -> next 0x200.
- Same cycle as a taken update at 0x40 (entry ctr 01): lookup 0x40 -> returns ctr-01 prediction (0x44). Next cycle -> 0x100.
- inv together with a taken update at 0xC0 -> every lookup misses afterwards.
- With BTB_STATS_EN: 5 updates, 2 of them mispredicted -> stat_branches 5, stat_mispredicts 2.
- Without BTB_STATS_EN: both stat ports read 0.

Source files
------------

// File: rtl/btb_predictor.sv
`timescale 1ns/1ps
// Two-bit dynamic branch predictor with a direct-mapped BTB, trained from MEM-stage branch resolutions.
// Optional feature macro: BTB_STATS_EN (resolved-branch and misprediction counters).
module btb_predictor #(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_en,
    input  logic [31:0] pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    input  logic        inv,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0]   lk_idx_s;
    logic [TAG_W-1:0]   lk_tag_s;
    logic               lk_hit_s;
    logic [IDX_W-1:0]   upd_idx_s;
    logic [TAG_W-1:0]   upd_tag_s;
    logic               upd_hit_s;
    logic               upd_train_s;
    logic               upd_alloc_s;
    logic [1:0]         ctr_d;
    logic               mispredict_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign lk_idx_s  = pc[IDX_W+1:2];
    assign lk_tag_s  = pc[31:IDX_W+2];
    assign lk_hit_s  = lookup_en & valid_q[lk_idx_s] & (tag_q[lk_idx_s] == lk_tag_s);

    assign pred_hit     = lk_hit_s;
    assign pred_taken   = lk_hit_s & ctr_q[lk_idx_s][1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx_s] : pc + 32'd4;

    assign upd_idx_s   = upd_pc[IDX_W+1:2];
    assign upd_tag_s   = upd_pc[31:IDX_W+2];
    assign upd_hit_s   = valid_q[upd_idx_s] & (tag_q[upd_idx_s] == upd_tag_s);
    assign upd_train_s = upd_valid & upd_hit_s;
    assign upd_alloc_s = upd_valid & ~upd_hit_s & upd_taken;

    // Next counter value for the entry addressed by the resolving branch
    always_comb begin
        ctr_d = ctr_q[upd_idx_s];
        if (upd_hit_s) begin
            if (upd_taken) begin
                ctr_d = sat_inc(ctr_q[upd_idx_s]);
            end else begin
                ctr_d = sat_dec(ctr_q[upd_idx_s]);
            end
        end else begin
            ctr_d = 2'b10;
        end
    end

    // Valid bits and counters: reset/invalidate to a known state, otherwise train or allocate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_CTR;
            end
        end else if (inv) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_CTR;
            end
        end else if (upd_train_s || upd_alloc_s) begin
            valid_q[upd_idx_s] <= 1'b1;
            ctr_q[upd_idx_s]   <= ctr_d;
        end
    end

    // Tags and targets need no reset: they are qualified by the valid bit
    always_ff @(posedge clk) begin
        if (!inv && upd_valid && upd_taken) begin
            tag_q[upd_idx_s]    <= upd_tag_s;
            target_q[upd_idx_s] <= upd_target;
        end
    end

    assign mispredict_s   = (upd_taken != upd_pred_taken) |
                            (upd_taken & upd_pred_taken & (upd_target != upd_pred_target));
    assign redirect_valid = upd_valid & mispredict_s;
    assign redirect_pc    = !redirect_valid ? 32'd0 :
                            (upd_taken ? upd_target : upd_pc + 32'd4);

`ifdef BTB_STATS_EN
    logic [15:0] stat_br_q;
    logic [15:0] stat_mis_q;

    // Saturating statistics; deliberately untouched by invalidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= 16'd0;
            stat_mis_q <= 16'd0;
        end else begin
            if (upd_valid && (stat_br_q != 16'hFFFF)) begin
                stat_br_q <= stat_br_q + 16'd1;
            end
            if (redirect_valid && (stat_mis_q != 16'hFFFF)) begin
                stat_mis_q <= stat_mis_q + 16'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = 16'd0;
    assign stat_mispredicts = 16'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
`timescale 1ns/1ps
// Randomized self-checking bench for btb_predictor against an array-based reference model.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_en;
    logic [31:0] pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        inv;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    btb_predictor #(.ENTRIES(16), .INIT_CTR(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_en(lookup_en), .pc(pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .inv(inv),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Reference model: one slot per index, tag kept as the full upper PC value
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_br;
    int          m_mis;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 32'd16);
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == (a >> 6));
    endfunction

    function automatic logic m_mispred();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
               (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    endfunction

    task automatic m_clear_table();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic m_reset();
        m_clear_table();
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic compare_all();
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_next;
        logic        e_mis;
        logic [31:0] e_rpc;
        int          i;
        i      = idx_of(pc);
        e_hit  = lookup_en && m_hit(pc);
        e_tk   = e_hit && (m_ctr[i] >= 2);
        e_next = e_tk ? m_tgt[i] : pc + 32'd4;
        e_mis  = m_mispred();
        e_rpc  = e_mis ? (upd_taken ? upd_target : upd_pc + 32'd4) : 32'd0;
        check_eq("pred_hit", {31'd0, pred_hit}, {31'd0, e_hit});
        check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
        check_eq("pred_next_pc", pred_next_pc, e_next);
        check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_mis});
        check_eq("redirect_pc", redirect_pc, e_rpc);
`ifdef BTB_STATS_EN
        check_eq("stat_branches", {16'd0, stat_branches}, 32'(m_br));
        check_eq("stat_mispredicts", {16'd0, stat_mispredicts}, 32'(m_mis));
`else
        check_eq("stat_branches", {16'd0, stat_branches}, 32'd0);
        check_eq("stat_mispredicts", {16'd0, stat_mispredicts}, 32'd0);
`endif
    endtask

    task automatic model_edge();
        int i;
        i = idx_of(upd_pc);
        if (upd_valid && m_br < 65535) m_br++;
        if (m_mispred() && m_mis < 65535) m_mis++;
        if (inv) begin
            m_clear_table();
        end else if (upd_valid) begin
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upd_pc >> 6;
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] p, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic upt, input logic [31:0] uptgt, input logic iv);
        lookup_en = en;  pc = p;  upd_valid = uv;  upd_pc = upc;  upd_taken = ut;
        upd_target = utgt;  upd_pred_taken = upt;  upd_pred_target = uptgt;  inv = iv;
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFC0 | ($urandom_range(0, 15) << 2);
        return p;
    endfunction

    initial begin
        logic [31:0] up;
        logic [31:0] ptgt;
        logic        pt;
        rst_n = 1'b0;
        m_reset();
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        step();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        step();
        step();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        step();
        step();
        drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'hC0, 1'b1, 32'hC0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        step();
        drive(1'b1, 32'hC0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();

        for (int n = 0; n < 400; n++) begin
            up   = rnd_pc();
            pt   = m_hit(up) && (m_ctr[idx_of(up)] >= 2);
            ptgt = m_hit(up) ? m_tgt[idx_of(up)] : rnd_pc();
            if ($urandom_range(0, 3) == 0) pt = ~pt;
            if ($urandom_range(0, 7) == 0) ptgt = rnd_pc();
            drive(($urandom_range(0, 7) != 0), rnd_pc(), ($urandom_range(0, 2) != 0), up,
                  ($urandom_range(0, 1) == 1), rnd_pc(), pt, ptgt, ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 3) == 0) pc = up;
            step();
            if (n == 200) begin
                rst_n = 1'b0;
                #1;
                m_reset();
                compare_all();
                #1 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
